// File: rtl/mem_arbiter_8085.sv
// Two-requester arbiter/sequencer for the shared 8085 unified memory.
// Each access is IDLE -> ACCESS -> DONE, so one access completes every three cycles.
module mem_arbiter_8085 #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 16,
  parameter int FIXED_PRI = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              done0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              done1,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_dataw,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_data
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic                owner_q, owner_d;
  logic                last_owner_q, last_owner_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata0_q, rdata0_d;
  logic [DATA_W-1:0]   rdata1_q, rdata1_d;
  logic                winner;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    winner       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          // A tie goes to the requester that was not served last, unless priority is fixed.
          if (req0 && req1) winner = (FIXED_PRI != 0) ? 1'b0 : ~last_owner_q;
          else              winner = req1;
          owner_d      = winner;
          last_owner_d = winner;
          we_d         = winner ? we1    : we0;
          addr_d       = winner ? addr1  : addr0;
          wdata_d      = winner ? wdata1 : wdata0;
          state_d      = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (!we_q) begin
          if (owner_q) rdata1_d = mem_data;
          else         rdata0_d = mem_data;
        end
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      // NOTE: non-blocking updates keep every register sampling pre-edge values.
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

  // Everything below decodes registered state only; no req reaches a strobe combinationally.
  assign gnt0      = (state_q != S_IDLE) && !owner_q;
  assign gnt1      = (state_q != S_IDLE) &&  owner_q;
  assign done0     = (state_q == S_DONE) && !owner_q;
  assign done1     = (state_q == S_DONE) &&  owner_q;
  assign mem_read  = (state_q == S_ACCESS) && !we_q;
  assign mem_write = (state_q == S_ACCESS) &&  we_q;
  assign mem_addr  = addr_q;
  assign mem_dataw = wdata_q;
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;

endmodule

// File: tb/tb_mem_arbiter_8085.sv
// Bench for mem_arbiter_8085: a round-robin and a fixed-priority instance share stimulus,
// each with its own memory, checked every cycle against a transaction-level model.
module tb_mem_arbiter_8085;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, we0, req1, we1;
  logic [7:0]  addr0, addr1;
  logic [15:0] wdata0, wdata1;

  logic [1:0]  gnt0_v, gnt1_v, done0_v, done1_v, mem_read_v, mem_write_v;
  logic [15:0] rdata0_v [2];
  logic [15:0] rdata1_v [2];
  logic [7:0]  mem_addr_v [2];
  logic [15:0] mem_dataw_v [2];
  logic [15:0] mem_data_v [2];

  logic [15:0] mem [2][256];
  logic        load_en;
  logic [7:0]  load_addr;
  logic [15:0] load_data;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: progress through the current transaction (0 free, 1 access, 2 done).
  int          m_busy  [2];
  bit          m_owner [2];
  bit          m_last  [2];
  bit          m_we    [2];
  logic [7:0]  m_addr  [2];
  logic [15:0] m_wdata [2];
  logic [15:0] m_rd    [2][2];
  logic [15:0] exp_mem [2][256];

  always #5 clk = ~clk;

  mem_arbiter_8085 #(.ADDR_W(8), .DATA_W(16), .FIXED_PRI(0)) dut_rr (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0_v[0]), .done0(done0_v[0]), .rdata0(rdata0_v[0]),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1_v[0]), .done1(done1_v[0]), .rdata1(rdata1_v[0]),
    .mem_addr(mem_addr_v[0]), .mem_dataw(mem_dataw_v[0]),
    .mem_read(mem_read_v[0]), .mem_write(mem_write_v[0]), .mem_data(mem_data_v[0])
  );

  mem_arbiter_8085 #(.ADDR_W(8), .DATA_W(16), .FIXED_PRI(1)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0_v[1]), .done0(done0_v[1]), .rdata0(rdata0_v[1]),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1_v[1]), .done1(done1_v[1]), .rdata1(rdata1_v[1]),
    .mem_addr(mem_addr_v[1]), .mem_dataw(mem_dataw_v[1]),
    .mem_read(mem_read_v[1]), .mem_write(mem_write_v[1]), .mem_data(mem_data_v[1])
  );

  assign mem_data_v[0] = mem[0][mem_addr_v[0]];
  assign mem_data_v[1] = mem[1][mem_addr_v[1]];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (load_en)             mem[k][load_addr]      <= load_data;
      else if (mem_write_v[k]) mem[k][mem_addr_v[k]] <= mem_dataw_v[k];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_busy[i]  = 0;
      m_owner[i] = 1'b0;
      m_last[i]  = 1'b1;
      m_we[i]    = 1'b0;
      m_addr[i]  = '0;
      m_wdata[i] = '0;
      m_rd[i][0] = '0;
      m_rd[i][1] = '0;
    end
  endtask

  // Instance 1 has fixed priority: requester 0 always wins a tie.
  task automatic model_step(input int i);
    bit w;
    case (m_busy[i])
      0: if (req0 || req1) begin
        if (req0 && req1) w = (i == 1) ? 1'b0 : !m_last[i];
        else              w = req1;
        m_owner[i] = w;
        m_last[i]  = w;
        m_we[i]    = w ? we1 : we0;
        m_addr[i]  = w ? addr1 : addr0;
        m_wdata[i] = w ? wdata1 : wdata0;
        m_busy[i]  = 1;
      end
      1: begin
        if (m_we[i]) exp_mem[i][m_addr[i]] = m_wdata[i];
        else         m_rd[i][m_owner[i]]   = exp_mem[i][m_addr[i]];
        m_busy[i] = 2;
      end
      default: m_busy[i] = 0;
    endcase
  endtask

  task automatic check_inst(input int i);
    string p;
    bit    acc;
    p   = (i == 0) ? "rr" : "fp";
    acc = (m_busy[i] == 1);
    check({p, ".gnt0"},  32'(gnt0_v[i]),  32'(m_busy[i] != 0 && !m_owner[i]));
    check({p, ".gnt1"},  32'(gnt1_v[i]),  32'(m_busy[i] != 0 &&  m_owner[i]));
    check({p, ".done0"}, 32'(done0_v[i]), 32'(m_busy[i] == 2 && !m_owner[i]));
    check({p, ".done1"}, 32'(done1_v[i]), 32'(m_busy[i] == 2 &&  m_owner[i]));
    check({p, ".mem_read"},  32'(mem_read_v[i]),  32'(acc && !m_we[i]));
    check({p, ".mem_write"}, 32'(mem_write_v[i]), 32'(acc &&  m_we[i]));
    check({p, ".rdata0"}, 32'(rdata0_v[i]), 32'(m_rd[i][0]));
    check({p, ".rdata1"}, 32'(rdata1_v[i]), 32'(m_rd[i][1]));
    if (acc) check({p, ".mem_addr"}, 32'(mem_addr_v[i]), 32'(m_addr[i]));
    if (acc && m_we[i]) check({p, ".mem_dataw"}, 32'(mem_dataw_v[i]), 32'(m_wdata[i]));
  endtask

  // Inputs are set before calling; outputs are compared at the following falling edge.
  task automatic tick();
    @(posedge clk);
    model_step(0);
    model_step(1);
    @(negedge clk);
    check_inst(0);
    check_inst(1);
  endtask

  task automatic go_idle();
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (3) tick();
  endtask

  // Asynchronous reset pulse placed mid-cycle, well clear of the rising edge.
  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_inst(0);
    check_inst(1);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int fp_done1;
    logic [15:0] d;
    rst_n = 1'b0;
    {req0, we0, req1, we1} = '0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    load_en = 1'b1; load_addr = '0; load_data = '0;
    model_reset();

    for (int a = 0; a < 256; a++) begin
      @(negedge clk);
      if (a == 8'h85)      d = 16'h0032;
      else if (a == 8'h40) d = 16'h5A5A;
      else                 d = 16'($urandom);
      load_addr = 8'(a);
      load_data = d;
      exp_mem[0][a] = d;
      exp_mem[1][a] = d;
    end
    @(negedge clk);
    load_en = 1'b0;
    check_inst(0);
    check_inst(1);
    #1 rst_n = 1'b1;

    // Single read of a preloaded location by requester 0.
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h85;
    tick();
    tick();
    check("read_0x85.rdata0", 32'(rdata0_v[0]), 32'h0032);
    req0 = 1'b0;
    tick();

    // Write then read back by requester 1.
    req1 = 1'b1; we1 = 1'b1; addr1 = 8'h10; wdata1 = 16'hBEEF;
    tick();
    tick();
    req1 = 1'b0;
    tick();
    req1 = 1'b1; we1 = 1'b0;
    tick();
    tick();
    check("readback_0x10.rdata1", 32'(rdata1_v[0]), 32'hBEEF);
    go_idle();

    // Continuous contention; the fixed-priority instance must never serve requester 1.
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h03;
    req1 = 1'b1; we1 = 1'b0; addr1 = 8'h04;
    fp_done1 = 0;
    repeat (12) begin
      tick();
      if (done1_v[1]) fp_done1++;
    end
    check("fp_contention.done1_count", 32'(fp_done1), 32'd0);
    req0 = 1'b0;
    repeat (6) tick();
    go_idle();

    // Fields changed and request dropped during ACCESS.
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h20;
    tick();
    addr0 = 8'h30;
    req0  = 1'b0;
    #1 check("field_change.mem_addr", 32'(mem_addr_v[0]), 32'h20);
    tick();
    check("field_change.done0", 32'(done0_v[0]), 32'd1);
    tick();

    // Reset asserted in the middle of a write access.
    req0 = 1'b1; we0 = 1'b1; addr0 = 8'h40; wdata0 = 16'h1234;
    tick();
    check("reset_write.mem_write_before", 32'(mem_write_v[0]), 32'd1);
    pulse_reset();
    check("reset_write.mem_write_after", 32'(mem_write_v[0]), 32'd0);
    req0 = 1'b1; we0 = 1'b0; req1 = 1'b1; we1 = 1'b0;
    tick();
    check("reset_write.first_tie_gnt0", 32'(gnt0_v[0]), 32'd1);
    check("reset_write.mem_unchanged", 32'(mem[0][8'h40]), 32'h5A5A);
    go_idle();

    // Randomised traffic on a small address window to provoke read-after-write hazards.
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 199) == 0) pulse_reset();
      req0   = ($urandom_range(0, 9) < 6);
      req1   = ($urandom_range(0, 9) < 6);
      we0    = 1'($urandom);
      we1    = 1'($urandom);
      addr0  = 8'($urandom_range(0, 15));
      addr1  = 8'($urandom_range(0, 15));
      wdata0 = 16'($urandom);
      wdata1 = 16'($urandom);
      tick();
    end
    go_idle();

    for (int k = 0; k < 2; k++)
      for (int a = 0; a < 16; a++)
        check($sformatf("final_mem[%0d][%0d]", k, a), 32'(mem[k][a]), 32'(exp_mem[k][a]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
